// File: rtl/rst_req_ctrl_if.sv
// Handshake bundle between a reset-request source and rst_req_ctrl.
// Requests flow in; the registered reset request and status flow out.
interface rst_req_ctrl_if;
    logic       sw_req_i;
    logic       hw_req_i;
    logic       clr_cause_i;
    logic       arst_req_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] cause_o;

    modport master (
        output sw_req_i,
        output hw_req_i,
        output clr_cause_i,
        input  arst_req_o,
        input  busy_o,
        input  done_o,
        input  cause_o
    );

    modport slave (
        input  sw_req_i,
        input  hw_req_i,
        input  clr_cause_i,
        output arst_req_o,
        output busy_o,
        output done_o,
        output cause_o
    );
endinterface

// File: rtl/rst_req_ctrl.sv
// Reset request controller: stretches sw/hw requests into a fixed-width
// reset pulse followed by a mandatory cooldown window.
module rst_req_ctrl #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input logic           ref_clk_i,
    input logic           arst_ni,
    rst_req_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        COOLDOWN = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] COOL_LD = 8'(COOLDOWN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sw_q;
    logic       pend_q, pend_d;
    logic [1:0] cause_q, cause_d;

    logic sw_ev;
    logic hw;
    logic cnt_zero;
    logic enter;

    assign sw_ev    = bus.sw_req_i & ~sw_q;
    assign hw       = bus.hw_req_i;
    assign cnt_zero = (cnt_q == 8'd0);
    // Extensions (ASSERT->ASSERT) are not entries and leave cause alone
    assign enter    = (state_d == ASSERT) && (state_q != ASSERT);

    always_ff @(posedge ref_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sw_ev || hw) state_d = ASSERT;
            end
            ASSERT: begin
                if (cnt_zero && !hw) state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt_zero) begin
                    if (pend_q || hw || sw_ev) state_d = ASSERT;
                    else                       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        unique case (state_q)
            IDLE: begin
                if (enter) cnt_d = HOLD_LD;
            end
            ASSERT: begin
                if (!cnt_zero) cnt_d = cnt_q - 8'd1;
                else if (hw)   cnt_d = HOLD_LD;
                else           cnt_d = COOL_LD;
            end
            COOLDOWN: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 8'd1;
                    if (sw_ev) pend_d = 1'b1;
                end else begin
                    cnt_d  = enter ? HOLD_LD : 8'd0;
                    pend_d = 1'b0;
                end
            end
            default: begin
                cnt_d  = 8'd0;
                pend_d = 1'b0;
            end
        endcase
        // A same-cycle set beats the clear
        cause_d = (cause_q & ~{2{bus.clr_cause_i}})
                | {enter & hw, enter & (sw_ev | pend_q)};
    end

    // Delay flop resets high so a level held across reset is not an edge
    always_ff @(posedge ref_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q   <= 8'd0;
            sw_q    <= 1'b1;
            pend_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            sw_q    <= bus.sw_req_i;
            pend_q  <= pend_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        bus.arst_req_o = (state_q == ASSERT);
        bus.busy_o     = (state_q != IDLE);
        bus.done_o     = (state_q == COOLDOWN) && cnt_zero;
        bus.cause_o    = cause_q;
    end
endmodule
